// File: rtl/pc_unit_if.sv
// Fetch-stage PC bundle: redirect controls in, current PC and RAS status out.
// Latency: none (wires only).
// Backpressure: stall is carried here; the driver holds the controls while stall is high.
interface pc_unit_if #(
  parameter int N = 32
);
  logic         stall;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         jump;
  logic         call;
  logic         ret;
  logic [N-1:0] jump_target;
  logic [N-1:0] pc;
  logic [N-1:0] pc_plus;
  logic         ras_empty;
  logic         ras_full;
  logic         ras_underflow;
  logic         misaligned;

  // Sequencer / decode side: drives redirects and watches the PC.
  modport master (
    output stall, branch_taken, branch_target, jump, call, ret, jump_target,
    input  pc, pc_plus, ras_empty, ras_full, ras_underflow, misaligned
  );

  // PC unit side.
  modport slave (
    input  stall, branch_taken, branch_target, jump, call, ret, jump_target,
    output pc, pc_plus, ras_empty, ras_full, ras_underflow, misaligned
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC select and a circular return-address stack.
// Latency: every selection lands on pc at the next rising edge (one cycle).
// Backpressure: stall freezes pc and the RAS and ignores all redirect inputs.
module pc_unit #(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = '0,
  parameter int           INC          = 4,
  parameter int           RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     rst,
  pc_unit_if.slave pc_bus
);

  localparam int            PW      = $clog2(RAS_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);
  localparam int            IW      = (INC > 1) ? $clog2(INC) : 1;

  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  pc_plus;
  logic [PW-1:0] top_q, top_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty_q, full_q;
  logic          unf_q, unf_d;
  logic [N-1:0]  ras_q [RAS_DEPTH];

  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [N-1:0]  wr_dat;

  assign pc_plus = pc_q + N'(INC);

  // Next-PC select and RAS bookkeeping; ret outranks everything but stall,
  // and a simultaneous call turns the pop+push into an in-place overwrite.
  always_comb begin
    pc_d   = pc_plus;
    top_d  = top_q;
    cnt_d  = cnt_q;
    unf_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = top_q + PW'(1);
    wr_dat = pc_plus;
    if (pc_bus.stall) begin
      pc_d = pc_q;
    end else if (pc_bus.ret && pc_bus.call) begin
      pc_d  = pc_bus.jump_target;
      wr_en = 1'b1;
      if (cnt_q != '0) begin
        wr_idx = top_q;
      end else begin
        top_d = top_q + PW'(1);
        cnt_d = CW'(1);
      end
    end else if (pc_bus.ret) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (pc_bus.call) begin
      pc_d  = pc_bus.jump_target;
      wr_en = 1'b1;
      top_d = top_q + PW'(1);
      // Full stack wraps over its oldest entry; count saturates.
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + CW'(1);
    end else if (pc_bus.jump) begin
      pc_d = pc_bus.jump_target;
    end else if (pc_bus.branch_taken) begin
      pc_d = pc_bus.branch_target;
    end
  end

  // PC, stack pointer, count and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == DEPTH_C);
      unf_q   <= unf_d;
    end
  end

  // Stack storage; contents are only ever read below a valid count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_idx] <= wr_dat;
  end

  generate
    if (INC == 1) begin : g_no_align
      assign pc_bus.misaligned = 1'b0;
    end else begin : g_align
      assign pc_bus.misaligned = |pc_q[IW-1:0];
    end
  endgenerate

  assign pc_bus.pc            = pc_q;
  assign pc_bus.pc_plus       = pc_plus;
  assign pc_bus.ras_empty     = empty_q;
  assign pc_bus.ras_full      = full_q;
  assign pc_bus.ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, stall, call/return, RAS wrap, wrap-around, async reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stall exercised directly against a pending branch.
module tb_pc_unit;
  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  pc_unit_if #(.N(32)) bus ();

  pc_unit #(
    .N(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pc_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl;
    bus.stall = 0; bus.branch_taken = 0; bus.jump = 0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_ctl();
    bus.branch_target = '0; bus.jump_target = '0;
    #1 rst = 1'b1;
    #2;
    vecs++; if (bus.pc !== 32'h0) begin errs++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
    vecs++; if (bus.ras_empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b exp=1", bus.ras_empty); end
    vecs++; if (bus.ras_full !== 1'b0) begin errs++; $display("FAIL reset_full got=%b exp=0", bus.ras_full); end
    vecs++; if (bus.ras_underflow !== 1'b0) begin errs++; $display("FAIL reset_unf got=%b exp=0", bus.ras_underflow); end
    vecs++; if (bus.misaligned !== 1'b0) begin errs++; $display("FAIL reset_mis got=%b exp=0", bus.misaligned); end
    tick();
    rst = 1'b0;
    vecs++; if (bus.pc !== 32'h0) begin errs++; $display("FAIL reset_hold got=%h exp=%h", bus.pc, 32'h0); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      vecs++; if (bus.pc !== 32'(4 * i)) begin errs++; $display("FAIL idle_pc[%0d] got=%h exp=%h", i, bus.pc, 32'(4 * i)); end
      vecs++; if (bus.pc_plus !== 32'(4 * i + 4)) begin errs++; $display("FAIL idle_plus[%0d] got=%h exp=%h", i, bus.pc_plus, 32'(4 * i + 4)); end
    end
    vecs++; if (bus.ras_empty !== 1'b1) begin errs++; $display("FAIL idle_empty got=%b exp=1", bus.ras_empty); end
  endtask

  task automatic test_stall;
    bus.jump = 1; bus.jump_target = 32'h10;
    tick();
    bus.jump = 0;
    vecs++; if (bus.pc !== 32'h10) begin errs++; $display("FAIL stall_setup got=%h exp=%h", bus.pc, 32'h10); end
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h80;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if (bus.pc !== 32'h10) begin errs++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, bus.pc, 32'h10); end
    end
    bus.stall = 0;
    tick();
    vecs++; if (bus.pc !== 32'h80) begin errs++; $display("FAIL stall_release got=%h exp=%h", bus.pc, 32'h80); end
    bus.jump = 1; bus.jump_target = 32'h100; bus.branch_target = 32'h180;
    tick();
    bus.jump = 0; bus.branch_taken = 0;
    vecs++; if (bus.pc !== 32'h100) begin errs++; $display("FAIL jump_over_branch got=%h exp=%h", bus.pc, 32'h100); end
  endtask

  task automatic test_call_ret;
    bus.call = 1; bus.jump_target = 32'h200;
    tick();
    vecs++; if (bus.pc !== 32'h200) begin errs++; $display("FAIL call1 got=%h exp=%h", bus.pc, 32'h200); end
    vecs++; if (bus.ras_empty !== 1'b0) begin errs++; $display("FAIL call1_empty got=%b exp=0", bus.ras_empty); end
    bus.call = 0;
    tick();
    vecs++; if (bus.pc !== 32'h204) begin errs++; $display("FAIL call_seq got=%h exp=%h", bus.pc, 32'h204); end
    bus.call = 1; bus.jump_target = 32'h300;
    tick();
    vecs++; if (bus.pc !== 32'h300) begin errs++; $display("FAIL call2 got=%h exp=%h", bus.pc, 32'h300); end
    bus.call = 0; bus.ret = 1;
    tick();
    vecs++; if (bus.pc !== 32'h208) begin errs++; $display("FAIL ret1 got=%h exp=%h", bus.pc, 32'h208); end
    tick();
    vecs++; if (bus.pc !== 32'h104) begin errs++; $display("FAIL ret2 got=%h exp=%h", bus.pc, 32'h104); end
    vecs++; if (bus.ras_empty !== 1'b1) begin errs++; $display("FAIL ret2_empty got=%b exp=1", bus.ras_empty); end
    vecs++; if (bus.ras_underflow !== 1'b0) begin errs++; $display("FAIL ret2_unf got=%b exp=0", bus.ras_underflow); end
    bus.ret = 0;
  endtask

  task automatic test_overflow;
    bus.jump = 1; bus.jump_target = 32'h0;
    tick();
    bus.jump = 0;
    vecs++; if (bus.pc !== 32'h0) begin errs++; $display("FAIL ovf_setup got=%h exp=%h", bus.pc, 32'h0); end
    for (int i = 0; i < 5; i++) begin
      bus.call = 1; bus.jump_target = 32'((i + 1) * 16);
      tick();
      vecs++; if (bus.pc !== 32'((i + 1) * 16)) begin errs++; $display("FAIL ovf_call[%0d] got=%h exp=%h", i, bus.pc, 32'((i + 1) * 16)); end
      vecs++; if (bus.ras_full !== (i >= 3)) begin errs++; $display("FAIL ovf_full[%0d] got=%b exp=%b", i, bus.ras_full, (i >= 3)); end
    end
    bus.call = 0; bus.ret = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++; if (bus.pc !== 32'(32'h44 - 16 * i)) begin errs++; $display("FAIL ovf_ret[%0d] got=%h exp=%h", i, bus.pc, 32'(32'h44 - 16 * i)); end
    end
    vecs++; if (bus.ras_empty !== 1'b1) begin errs++; $display("FAIL ovf_empty got=%b exp=1", bus.ras_empty); end
    vecs++; if (bus.ras_full !== 1'b0) begin errs++; $display("FAIL ovf_notfull got=%b exp=0", bus.ras_full); end
    tick();
    vecs++; if (bus.pc !== 32'h18) begin errs++; $display("FAIL unf_pc got=%h exp=%h", bus.pc, 32'h18); end
    vecs++; if (bus.ras_underflow !== 1'b1) begin errs++; $display("FAIL unf_pulse got=%b exp=1", bus.ras_underflow); end
    bus.ret = 0;
    tick();
    vecs++; if (bus.pc !== 32'h1c) begin errs++; $display("FAIL unf_after_pc got=%h exp=%h", bus.pc, 32'h1c); end
    vecs++; if (bus.ras_underflow !== 1'b0) begin errs++; $display("FAIL unf_clear got=%b exp=0", bus.ras_underflow); end
  endtask

  task automatic test_call_ret_same;
    bus.jump = 1; bus.jump_target = 32'h500;
    tick();
    bus.jump = 0; bus.call = 1; bus.jump_target = 32'h600;
    tick();
    bus.ret = 1; bus.jump_target = 32'h700;
    tick();
    vecs++; if (bus.pc !== 32'h700) begin errs++; $display("FAIL cr_full_pc got=%h exp=%h", bus.pc, 32'h700); end
    vecs++; if (bus.ras_empty !== 1'b0) begin errs++; $display("FAIL cr_full_empty got=%b exp=0", bus.ras_empty); end
    bus.call = 0;
    tick();
    vecs++; if (bus.pc !== 32'h604) begin errs++; $display("FAIL cr_overwrite got=%h exp=%h", bus.pc, 32'h604); end
    vecs++; if (bus.ras_empty !== 1'b1) begin errs++; $display("FAIL cr_count got=%b exp=1", bus.ras_empty); end
    bus.call = 1; bus.jump_target = 32'h800;
    tick();
    vecs++; if (bus.pc !== 32'h800) begin errs++; $display("FAIL cr_empty_pc got=%h exp=%h", bus.pc, 32'h800); end
    vecs++; if (bus.ras_empty !== 1'b0) begin errs++; $display("FAIL cr_empty_push got=%b exp=0", bus.ras_empty); end
    vecs++; if (bus.ras_underflow !== 1'b0) begin errs++; $display("FAIL cr_empty_unf got=%b exp=0", bus.ras_underflow); end
    bus.call = 0;
    tick();
    vecs++; if (bus.pc !== 32'h608) begin errs++; $display("FAIL cr_pop got=%h exp=%h", bus.pc, 32'h608); end
    bus.jump = 1; bus.jump_target = 32'h900;
    tick();
    vecs++; if (bus.pc !== 32'h60c) begin errs++; $display("FAIL ret_over_jump got=%h exp=%h", bus.pc, 32'h60c); end
    vecs++; if (bus.ras_underflow !== 1'b1) begin errs++; $display("FAIL ret_over_jump_unf got=%b exp=1", bus.ras_underflow); end
    bus.ret = 0; bus.jump = 0;
  endtask

  task automatic test_wrap_misalign;
    bus.jump = 1; bus.jump_target = 32'hFFFF_FFFC;
    tick();
    bus.jump = 0;
    vecs++; if (bus.pc_plus !== 32'h0) begin errs++; $display("FAIL wrap_plus got=%h exp=%h", bus.pc_plus, 32'h0); end
    tick();
    vecs++; if (bus.pc !== 32'h0) begin errs++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 32'h0); end
    bus.jump = 1; bus.jump_target = 32'h102;
    tick();
    bus.jump = 0;
    vecs++; if (bus.pc !== 32'h102) begin errs++; $display("FAIL mis_pc got=%h exp=%h", bus.pc, 32'h102); end
    vecs++; if (bus.misaligned !== 1'b1) begin errs++; $display("FAIL mis_flag got=%b exp=1", bus.misaligned); end
    tick();
    vecs++; if (bus.pc !== 32'h106) begin errs++; $display("FAIL mis_seq got=%h exp=%h", bus.pc, 32'h106); end
    bus.call = 1; bus.jump_target = 32'h200;
    tick();
    bus.jump_target = 32'h300;
    tick();
    bus.call = 0;
    vecs++; if (bus.pc !== 32'h300) begin errs++; $display("FAIL rst_chain got=%h exp=%h", bus.pc, 32'h300); end
    #1 rst = 1'b1;
    #1;
    vecs++; if (bus.pc !== 32'h0) begin errs++; $display("FAIL rst_async_pc got=%h exp=%h", bus.pc, 32'h0); end
    vecs++; if (bus.ras_empty !== 1'b1) begin errs++; $display("FAIL rst_async_empty got=%b exp=1", bus.ras_empty); end
    tick();
    rst = 1'b0;
    tick();
    vecs++; if (bus.pc !== 32'h4) begin errs++; $display("FAIL rst_release got=%h exp=%h", bus.pc, 32'h4); end
    bus.ret = 1;
    tick();
    bus.ret = 0;
    vecs++; if (bus.pc !== 32'h8) begin errs++; $display("FAIL rst_discard_pc got=%h exp=%h", bus.pc, 32'h8); end
    vecs++; if (bus.ras_underflow !== 1'b1) begin errs++; $display("FAIL rst_discard_unf got=%b exp=1", bus.ras_underflow); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_stall();
    test_call_ret();
    test_overflow();
    test_call_ret_same();
    test_wrap_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
